barrel_shift_pipe: RTL and testbench
====================================

// Module: barrel_shift_pipe
// PURPOSE
//   Parametrised, pipelined barrel shifter for the ALU shift path. Supports
//   logical left, logical right, arithmetic right and rotate left.
//   Produces carry-out and zero flags alongside the result.
//   Has one register stage per log2 shift stage, with valid/ready flow control,
//   so it sits between the operand-fetch and writeback stages of the datapath.
// PARAMETERS
//   WIDTH   16   data width; power of two, >= 4
//   SHW     $clog2(WIDTH)   localparam; shift-amount width = pipeline depth
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      input operand valid
//   in_ready   out  1      shifter can accept the operand this cycle
//   in_data    in   WIDTH  operand
//   shft       in   SHW    shift amount, 0..WIDTH-1
//   op         in   2      00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts the result
//   out_data   out  WIDTH  shifted result
//   out_carry  out  1      last bit shifted out (see below)
//   out_zero   out  1      out_data == 0
// BEHAVIOUR
//   - Structure: SHW stages. Stage k shifts by 2^k when shft[k]=1, then
//     registers its data, op, remaining shft bits, running carry and valid.
//     Stage 0 is fed from the inputs. The last stage drives the out_* signals.
//   - Latency: exactly SHW cycles from accept (in_valid & in_ready at an edge)
//     to out_valid, when there is no backpressure. Throughput is 1 per cycle.
//   - Fill bits: SLL and SRL fill with 0. SRA fills with in_data[WIDTH-1].
//     ROL wraps bits from the MSB into the LSB.
//   - Carry (a function of the original operand, amt = shft):
//     - amt == 0: 0.
//     - SLL: in_data[WIDTH-amt].
//     - SRL and SRA: in_data[amt-1].
//     - ROL: out_data[0].
//     - Each stage updates the carry only when its shft bit is 1.
//   - out_zero is computed from the final-stage data and registered with it.
//   - Flow control: stage k may load when it is empty or when stage k+1 loads
//     (or, for the last stage, when out_ready=1). in_ready equals stage 0's
//     load condition. The ready chain is combinational, so bubbles collapse.
//     A stage that is not loading holds its contents.
//   - out_data, out_carry and out_zero stay stable while out_valid=1 and
//     out_ready=0.
//   - Results leave in strict acceptance order; no operand is dropped or
//     duplicated.
//   - When the pipe is full and out_ready=1, accept and retire happen in the
//     same cycle and the pipe stays full.
//   - Reset:
//     - All stage valids go to 0 and all data/flag registers go to 0.
//     - out_valid=0, out_data=0, out_carry=0, out_zero=0.
//     - in_ready=0 while rst=1, and 1 on the first cycle after rst deasserts.
//     - Asserting rst mid-stream discards every in-flight operand.
//   - Input constraint: in_data, shft and op are sampled only on accept and
//     may change freely otherwise.
// TESTING (WIDTH=16, latency 4)
//   1 SLL 0x8001 shft=1 -> out_data=0x0002, carry=1, zero=0; out_valid
//     rises 4 cycles after accept.
//   2 SRA 0x8000 shft=15 -> 0xFFFF, carry=0. SRA 0x4000 shft=15 -> 0x0000,
//     carry=1, zero=1.
//   3 ROL 0x1234 shft=4 -> 0x2341, carry=1. ROL 0xABCD shft=0 -> 0xABCD,
//     carry=0.
//   4 SRL 0x00F0 shft=8 -> 0x0000, zero=1, carry=1. SRL 0x00F0 shft=4 ->
//     0x000F, carry=0.
//   5 Send 8 back-to-back ops with out_ready=0 from cycle 0 -> in_ready
//     drops after 4 accepts; then out_ready=1 -> all 8 results arrive in
//     order, 1 per cycle, none lost.
//   6 Fill the pipe with 3 ops, assert rst for 1 cycle -> out_valid stays 0;
//     the next op is accepted and its result is the only one to emerge.

Source files
------------

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter for the ALU shift path: SLL, SRL, SRA and ROL with
// carry-out and zero flags. Stage k applies the 2^k shift and owns one register.
module barrel_shift_pipe #(
   parameter  int WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   shft,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1; valid never waits for ready, and a stage holds its word until the
   // transfer that empties it, so results stay stable under backpressure.

   logic [SHW-1:0]   v_q;
   logic [WIDTH-1:0] d_q   [SHW];
   logic             c_q   [SHW];
   logic [1:0]       op_q  [SHW-1];
   logic [SHW-1:0]   sh_q  [SHW-1];
   logic             z_q;

   logic [WIDTH-1:0] st_din  [SHW];
   logic [WIDTH-1:0] st_dout [SHW];
   logic [1:0]       st_op   [SHW];
   logic [SHW-1:0]   st_sh   [SHW];
   logic             st_cin  [SHW];
   logic             st_cout [SHW];
   logic             st_vin  [SHW];
   logic [SHW-1:0]   load;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int S = 1 << k;
      logic [WIDTH-1:0] dsh;
      logic             csh;

      if (k == 0) begin : g_head
         assign st_din[k] = in_data;
         assign st_op[k]  = op;
         assign st_sh[k]  = shft;
         assign st_cin[k] = 1'b0;
         assign st_vin[k] = in_valid & in_ready;
      end else begin : g_body
         assign st_din[k] = d_q[k-1];
         assign st_op[k]  = op_q[k-1];
         assign st_sh[k]  = sh_q[k-1];
         assign st_cin[k] = c_q[k-1];
         assign st_vin[k] = v_q[k-1];
      end

      // The carry is the last bit to leave; later stages overwrite it only when they shift.
      always_comb begin
         dsh = st_din[k];
         csh = st_cin[k];
         if (st_sh[k][0]) begin
            case (st_op[k])
               OP_SLL: begin
                  dsh = st_din[k] << S;
                  csh = st_din[k][WIDTH-S];
               end
               OP_SRL: begin
                  dsh = st_din[k] >> S;
                  csh = st_din[k][S-1];
               end
               OP_SRA: begin
                  dsh = $unsigned($signed(st_din[k]) >>> S);
                  csh = st_din[k][S-1];
               end
               OP_ROL: begin
                  dsh = {st_din[k][WIDTH-1-S:0], st_din[k][WIDTH-1:WIDTH-S]};
                  csh = st_din[k][WIDTH-S];
               end
            endcase
         end
      end

      assign st_dout[k] = dsh;
      assign st_cout[k] = csh;
   end

   // A stage may load if it, or any stage downstream of it, is empty, or the
   // sink is taking the result; this collapses bubbles in a single cycle.
   always_comb begin
      logic full;
      full = 1'b1;
      load = '0;
      for (int k = SHW - 1; k >= 0; k--) begin
         full    = full & v_q[k];
         load[k] = out_ready | ~full;
      end
   end

   assign in_ready = load[0] & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         z_q <= 1'b0;
         for (int k = 0; k < SHW; k++) begin
            d_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
         for (int k = 0; k < SHW - 1; k++) begin
            op_q[k] <= '0;
            sh_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < SHW; k++) begin
            if (load[k]) begin
               v_q[k] <= st_vin[k];
               d_q[k] <= st_dout[k];
               c_q[k] <= st_cout[k];
            end
         end
         // The shift amount moves down one bit per stage so bit 0 is always the current one.
         for (int k = 0; k < SHW - 1; k++) begin
            if (load[k]) begin
               op_q[k] <= st_op[k];
               sh_q[k] <= st_sh[k] >> 1;
            end
         end
         if (load[SHW-1]) begin
            z_q <= (st_dout[SHW-1] == '0);
         end
      end
   end

   logic unused_sh;
   assign unused_sh = ^st_sh[SHW-1][SHW-1:1];

   assign out_valid = v_q[SHW-1];
   assign out_data  = d_q[SHW-1];
   assign out_carry = c_q[SHW-1];
   assign out_zero  = z_q;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe (WIDTH=16, four stages): scoreboard of
// hand-computed results plus latency, backpressure and mid-stream reset steps.
module tb_barrel_shift_pipe;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [3:0]   shft;
   logic [1:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_carry;
   logic         out_zero;

   int tests   = 0;
   int fails   = 0;
   int retired = 0;
   int lat;
   int r0;

   logic [W+1:0] exp_q[$];
   logic [W+1:0] mon_e;

   barrel_shift_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .shft      (shft),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .out_zero  (out_zero)
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every retired result is matched against the oldest expectation
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         retired++;
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("res_data",  32'(out_data),  32'(mon_e[W+1:2]));
            chk("res_carry", 32'(out_carry), 32'(mon_e[1]));
            chk("res_zero",  32'(out_zero),  32'(mon_e[0]));
         end
      end
   end

   // driver: hold the operand until accepted, then scramble the inputs
   task automatic send(input logic [1:0] o, input logic [W-1:0] d, input logic [3:0] s,
                       input logic [W-1:0] ed, input logic ec, input logic ez, input bit keep);
      int budget = 0;
      in_valid = 1'b1;
      op       = o;
      in_data  = d;
      shft     = s;
      @(negedge clk);
      while (in_ready !== 1'b1 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (in_ready !== 1'b1) chk("accept_timeout", 32'(in_ready), 32'd1);
      else if (keep) exp_q.push_back({ed, ec, ez});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op       = 2'($urandom);
      in_data  = 16'($urandom);
      shft     = 4'($urandom);
   endtask

   task automatic drain(input string tag);
      int budget = 0;
      while (exp_q.size() != 0 && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      shft      = '0;
      op        = '0;
      out_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_carry", 32'(out_carry), 32'd0);
      chk("rst_out_zero",  32'(out_zero),  32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // SLL and latency: out_valid after the 4th edge, counting the accept edge
      send(2'b00, 16'h8001, 4'd1, 16'h0002, 1'b1, 1'b0, 1'b1);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (out_valid !== 1'b1 && lat < 20);
      chk("latency", 32'(lat), 32'd4);
      drain("drain_t1");

      // SRA, ROL, SRL vectors and shift-amount boundaries, back to back
      send(2'b10, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      send(2'b10, 16'h4000, 4'd15, 16'h0000, 1'b1, 1'b1, 1'b1);
      send(2'b11, 16'h1234, 4'd4,  16'h2341, 1'b1, 1'b0, 1'b1);
      send(2'b11, 16'hABCD, 4'd0,  16'hABCD, 1'b0, 1'b0, 1'b1);
      send(2'b01, 16'h00F0, 4'd8,  16'h0000, 1'b1, 1'b1, 1'b1);
      send(2'b01, 16'h00F0, 4'd4,  16'h000F, 1'b0, 1'b0, 1'b1);
      send(2'b00, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b0, 1'b1);
      send(2'b00, 16'h0003, 4'd15, 16'h8000, 1'b1, 1'b0, 1'b1);
      send(2'b11, 16'h0002, 4'd15, 16'h0001, 1'b1, 1'b0, 1'b1);
      send(2'b10, 16'h8001, 4'd1,  16'hC000, 1'b1, 1'b0, 1'b1);
      drain("drain_t2");

      // backpressure: four accepts fill the pipe, the head result holds
      out_ready = 1'b0;
      send(2'b00, 16'h0F0F, 4'd4,  16'hF0F0, 1'b0, 1'b0, 1'b1);
      send(2'b01, 16'hF000, 4'd12, 16'h000F, 1'b0, 1'b0, 1'b1);
      send(2'b10, 16'hA800, 4'd12, 16'hFFFA, 1'b1, 1'b0, 1'b1);
      send(2'b11, 16'h8421, 4'd1,  16'h0843, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready",   32'(in_ready),  32'd0);
         chk("bp_out_valid",  32'(out_valid), 32'd1);
         chk("bp_hold_data",  32'(out_data),  32'h0000F0F0);
         chk("bp_hold_carry", 32'(out_carry), 32'd0);
         chk("bp_hold_zero",  32'(out_zero),  32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      r0        = retired;
      send(2'b00, 16'hFFFF, 4'd8,  16'hFF00, 1'b1, 1'b0, 1'b1);
      send(2'b01, 16'h0001, 4'd1,  16'h0000, 1'b1, 1'b1, 1'b1);
      send(2'b11, 16'h0000, 4'd7,  16'h0000, 1'b0, 1'b1, 1'b1);
      send(2'b10, 16'h7FFF, 4'd3,  16'h0FFF, 1'b1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      #1;
      chk("bp_burst_count", 32'(retired - r0), 32'd8);
      drain("drain_t5");

      // mid-stream reset discards three in-flight operands
      r0 = retired;
      send(2'b00, 16'h1111, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
      send(2'b01, 16'h2222, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
      send(2'b11, 16'h3333, 4'd3, 16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk);
      #1;
      send(2'b11, 16'hABCD, 4'd8, 16'hCDAB, 1'b1, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      #1;
      chk("post_rst_only_one", 32'(retired - r0), 32'd1);
      chk("post_rst_queue",    32'(exp_q.size()), 32'd0);

      // final report
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
